load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, store masks and FSM encoding for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [31:0] MASK_B = 32'h0000_00FF;
    localparam logic [31:0] MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_LOAD  = 3'd2,
        WAIT_STORE = 3'd3,
        RESP       = 3'd4
    } lsu_state_e;

    // Stores only have signed-agnostic widths; unsigned codes are load-only.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [31:0] store_mask(input logic [2:0] f3);
        case (f3)
            F3_B:    return MASK_B;
            F3_H:    return MASK_H;
            F3_W:    return MASK_W;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and memory controller signals
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cmd_start;
    logic        mem_cmd_write;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of right-justified load data
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = 32'h0;
        case (i_funct3)
            F3_B:    o_data = {{24{i_rdata[7]}}, i_rdata[7:0]};
            F3_BU:   o_data = {24'h0, i_rdata[7:0]};
            F3_H:    o_data = {{16{i_rdata[15]}}, i_rdata[15:0]};
            F3_HU:   o_data = {16'h0, i_rdata[15:0]};
            F3_W:    o_data = i_rdata;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit in front of an unaligned memory controller
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    lsu_state_e  r_state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wmask;
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;
    logic        r_err;

    logic        w_accept;
    logic        w_issue;
    logic        w_resp;
    logic        w_timeout;
    logic [31:0] w_ext;
    logic [31:0] w_mask;

    lsu_load_extend u_load_extend (
        .i_funct3 (r_funct3),
        .i_rdata  (bus.mem_rdata),
        .o_data   (w_ext)
    );

    assign w_issue   = (r_state == ISSUE);
    assign w_resp    = (r_state == RESP);
    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_timeout = TO_EN && (r_cnt == TO_LAST);
    assign w_mask    = bus.req_write ? store_mask(bus.req_funct3) : 32'h0;

    assign bus.req_ready     = (r_state == IDLE);
    assign bus.mem_cmd_start = w_issue && bus.mem_cmd_ready;
    assign bus.mem_cmd_write = w_issue && r_write;
    assign bus.mem_addr      = w_issue ? r_addr  : 32'h0;
    assign bus.mem_wdata     = w_issue ? r_wdata : 32'h0;
    assign bus.mem_wmask     = w_issue ? r_wmask : 32'h0;
    assign bus.resp_valid    = w_resp;
    assign bus.resp_rdata    = w_resp ? r_rdata : 32'h0;
    assign bus.resp_err      = w_resp && r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_wmask  <= 32'h0;
            r_rdata  <= 32'h0;
            r_cnt    <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wmask  <= w_mask;
                        r_wdata  <= bus.req_wdata & w_mask;
                        r_rdata  <= 32'h0;
                        r_cnt    <= 32'h0;
                        if (f3_legal(bus.req_write, bus.req_funct3)) begin
                            r_err   <= 1'b0;
                            r_state <= ISSUE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (bus.mem_cmd_ready) begin
                        r_state <= r_write ? WAIT_STORE : WAIT_LOAD;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                WAIT_LOAD: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (bus.mem_rdata_valid) begin
                        r_rdata <= w_ext;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                        r_state <= RESP;
                    end
                end
                WAIT_STORE: begin
                    r_cnt <= r_cnt + 32'd1;
                    // Controller raises ready again only once it has drained the write.
                    if (bus.mem_cmd_ready) begin
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
`timescale 1ns/1ps
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if itf ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (itf)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_start = 0;
    logic stuck = 1'b0;

    logic [7:0]  mem [0:511];
    logic        cap_write;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] cap_wmask;

    function automatic logic [31:0] rd32(input logic [31:0] a);
        logic [8:0] i;
        i = a[8:0];
        return {mem[i + 9'd3], mem[i + 9'd2], mem[i + 9'd1], mem[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Controller model: busy two cycles after a start, returns load data right-justified.
    initial begin
        itf.mem_cmd_ready   = 1'b1;
        itf.mem_rdata       = 32'h0;
        itf.mem_rdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (itf.mem_cmd_start === 1'b1) begin
                n_start++;
                cap_write = itf.mem_cmd_write;
                cap_addr  = itf.mem_addr;
                cap_wdata = itf.mem_wdata;
                cap_wmask = itf.mem_wmask;
                @(posedge clk); #1;
                itf.mem_cmd_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                if (!cap_write) begin
                    itf.mem_rdata       = rd32(cap_addr);
                    itf.mem_rdata_valid = 1'b1;
                    @(posedge clk); #1;
                    itf.mem_rdata_valid = 1'b0;
                    itf.mem_rdata       = 32'h0;
                end
                itf.mem_cmd_ready = 1'b1;
            end else begin
                itf.mem_cmd_ready = !stuck;
            end
        end
    end

    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        logic got;
        itf.req_valid  = 1'b1;
        itf.req_write  = w;
        itf.req_funct3 = f3;
        itf.req_addr   = addr;
        itf.req_wdata  = wdata;
        @(posedge clk); #1;
        itf.req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (itf.resp_valid === 1'b1) got = 1'b1;
        end
        rdata = itf.resp_rdata;
        err   = itf.resp_err;
        check("resp_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("resp_one_cycle", 32'(itf.resp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          s0;
    int          seen;

    initial begin
        itf.req_valid  = 1'b0;
        itf.req_write  = 1'b0;
        itf.req_funct3 = 3'd0;
        itf.req_addr   = 32'h0;
        itf.req_wdata  = 32'h0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        {mem[9'h103], mem[9'h102], mem[9'h101], mem[9'h100]} = 32'hDEADBEEF;
        {mem[9'h107], mem[9'h106], mem[9'h105], mem[9'h104]} = 32'h11223344;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(itf.req_ready), 32'd1);
        check("rst_resp_valid", 32'(itf.resp_valid), 32'd0);
        check("rst_cmd_start", 32'(itf.mem_cmd_start), 32'd0);
        check("rst_mem_addr", itf.mem_addr, 32'h0);
        check("rst_resp_rdata", itf.resp_rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        s0 = n_start;
        access(1'b0, 3'd0, 32'h101, 32'h0, rd, er, lat);
        check("lb_rdata", rd, 32'hFFFFFFBE);
        check("lb_err", 32'(er), 32'd0);
        check("lb_latency", 32'(lat), 32'd5);
        check("lb_starts", 32'(n_start - s0), 32'd1);
        check("lb_cmd_write", 32'(cap_write), 32'd0);
        check("lb_cmd_addr", cap_addr, 32'h101);

        access(1'b0, 3'd4, 32'h101, 32'h0, rd, er, lat);
        check("lbu_rdata", rd, 32'h000000BE);
        access(1'b0, 3'd1, 32'h102, 32'h0, rd, er, lat);
        check("lh_rdata", rd, 32'hFFFFDEAD);
        access(1'b0, 3'd5, 32'h102, 32'h0, rd, er, lat);
        check("lhu_rdata", rd, 32'h0000DEAD);
        access(1'b0, 3'd2, 32'h101, 32'h0, rd, er, lat);
        check("lw_unaligned_rdata", rd, 32'h44DEADBE);

        s0 = n_start;
        access(1'b1, 3'd0, 32'h103, 32'h12345678, rd, er, lat);
        check("sb_starts", 32'(n_start - s0), 32'd1);
        check("sb_cmd_write", 32'(cap_write), 32'd1);
        check("sb_cmd_addr", cap_addr, 32'h103);
        check("sb_wmask", cap_wmask, 32'h000000FF);
        check("sb_wdata", cap_wdata, 32'h00000078);
        check("sb_err", 32'(er), 32'd0);
        check("sb_rdata", rd, 32'h0);
        check("sb_latency", 32'(lat), 32'd5);
        check("idle_mem_addr", itf.mem_addr, 32'h0);
        check("idle_mem_wmask", itf.mem_wmask, 32'h0);

        access(1'b1, 3'd1, 32'h200, 32'hCAFEBABE, rd, er, lat);
        check("sh_wmask", cap_wmask, 32'h0000FFFF);
        check("sh_wdata", cap_wdata, 32'h0000BABE);
        access(1'b1, 3'd2, 32'h1FE, 32'hA5A55A5A, rd, er, lat);
        check("sw_wmask", cap_wmask, 32'hFFFFFFFF);
        check("sw_wdata", cap_wdata, 32'hA5A55A5A);

        s0 = n_start;
        access(1'b0, 3'd3, 32'h100, 32'h0, rd, er, lat);
        check("ill_load_err", 32'(er), 32'd1);
        check("ill_load_latency", 32'(lat), 32'd1);
        check("ill_load_rdata", rd, 32'h0);
        access(1'b1, 3'd4, 32'h100, 32'hFFFFFFFF, rd, er, lat);
        check("ill_store_err", 32'(er), 32'd1);
        check("ill_starts", 32'(n_start - s0), 32'd0);

        stuck = 1'b1;
        repeat (2) @(negedge clk);
        s0 = n_start;
        access(1'b0, 3'd2, 32'h100, 32'h0, rd, er, lat);
        check("to_err", 32'(er), 32'd1);
        check("to_rdata", rd, 32'h0);
        check("to_latency", 32'(lat), 32'd17);
        check("to_starts", 32'(n_start - s0), 32'd0);
        stuck = 1'b0;
        repeat (2) @(negedge clk);

        itf.req_valid  = 1'b1;
        itf.req_write  = 1'b0;
        itf.req_funct3 = 3'd2;
        itf.req_addr   = 32'h100;
        @(posedge clk); #1;
        itf.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(itf.req_ready), 32'd1);
        check("midrst_resp_valid", 32'(itf.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (itf.resp_valid !== 1'b0) seen++;
        end
        check("midrst_no_resp", 32'(seen), 32'd0);

        access(1'b0, 3'd2, 32'h104, 32'h0, rd, er, lat);
        check("post_rst_lw_rdata", rd, 32'h11223344);
        check("post_rst_lw_err", 32'(er), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
